// File: rtl/inst_sram_bridge.sv
// Fetch-side bridge from the pipeline PC to an SRAM-like instruction bus.
// Issues one request per PC, buffers the returned word until the pipeline takes it.
module inst_sram_bridge #(
    parameter bit          MAP_KSEG = 1'b1,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [31:0] instrF,
    output logic        instr_valid,
    output logic        fetch_adel,
    output logic        i_stall,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [2:0]  dbgState
);

    // Bus handshake: a request is accepted in the cycle where inst_req and
    // inst_addr_ok are both high; inst_addr is held stable until then. The
    // response is the single inst_data_ok pulse that follows acceptance.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        DONE    = 3'd3,
        DISCARD = 3'd4
    } fetchState_t;

    fetchState_t state;
    logic [31:0] addrQ;
    logic [31:0] bufQ;
    logic        dropQ;
    logic        adelQ;

    logic [31:0] pcAddr;
    logic        misaligned;

    function automatic logic [31:0] xlate(input logic [31:0] pc);
        if (MAP_KSEG && (pc[31:30] == 2'b10)) begin
            return {3'b000, pc[28:0]};
        end
        return pc;
    endfunction

    assign pcAddr     = xlate(pcF);
    assign misaligned = (pcF[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            addrQ <= 32'h0;
            bufQ  <= 32'h0;
            dropQ <= 1'b0;
            adelQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addrQ <= pcAddr;
                    if (misaligned) begin
                        adelQ <= 1'b1;
                        state <= DONE;
                    end else if (inst_addr_ok) begin
                        dropQ <= 1'b0;
                        state <= flush ? DISCARD : WAIT;
                    end else begin
                        dropQ <= flush;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (inst_addr_ok) begin
                        dropQ <= 1'b0;
                        state <= (dropQ || flush) ? DISCARD : WAIT;
                    end else if (flush) begin
                        dropQ <= 1'b1;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (!flush) begin
                            bufQ  <= inst_rdata;
                            state <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush) begin
                        state <= DISCARD;
                    end
                end
                DONE: begin
                    if (fetch_en || flush) begin
                        adelQ <= 1'b0;
                        state <= IDLE;
                    end
                end
                DISCARD: begin
                    // The response to an abandoned request still has to drain.
                    if (inst_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset is async, so state is already IDLE while rst is low; only the
    // IDLE request needs an explicit gate.
    assign inst_req    = rst && (((state == IDLE) && !misaligned) || (state == REQ));
    assign inst_addr   = (state == IDLE) ? pcAddr : addrQ;
    assign inst_wr     = 1'b0;
    assign inst_size   = 2'b10;
    assign inst_wdata  = 32'h0;

    assign instr_valid = (state == DONE);
    assign i_stall     = (state != DONE);
    assign fetch_adel  = (state == DONE) && adelQ;
    assign instrF      = ((state == DONE) && !adelQ) ? bufQ : NOP_WORD;
    assign dbgState    = state;

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Directed bench for inst_sram_bridge: the bench plays the bus slave and the
// pipeline, and checks returned words through an expected-instruction queue.
module tb_inst_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        fetch_en;
    logic        flush;
    logic [31:0] instrF;
    logic        instr_valid;
    logic        fetch_adel;
    logic        i_stall;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [2:0]  dbgState;

    localparam logic [31:0] S_IDLE    = 32'd0;
    localparam logic [31:0] S_REQ     = 32'd1;
    localparam logic [31:0] S_WAIT    = 32'd2;
    localparam logic [31:0] S_DONE    = 32'd3;
    localparam logic [31:0] S_DISCARD = 32'd4;

    int testCount = 0;
    int failCount = 0;
    logic [31:0] exp_q[$];

    inst_sram_bridge #(.MAP_KSEG(1'b1), .NOP_WORD(32'h0)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .fetch_en(fetch_en), .flush(flush),
        .instrF(instrF), .instr_valid(instr_valid), .fetch_adel(fetch_adel),
        .i_stall(i_stall), .inst_req(inst_req), .inst_wr(inst_wr),
        .inst_size(inst_size), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare instrF against the oldest word the bench expects to see.
    task automatic popChk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            testCount++;
            failCount++;
            $error("FAIL %s: observed %h expected nothing queued", tag, instrF);
        end else begin
            e = exp_q.pop_front();
            chk(tag, instrF, e);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then sample at the falling edge.
    task automatic cyc(input logic [31:0] pc, input logic fe, input logic fl,
                       input logic aok, input logic dok, input logic [31:0] rd);
        @(posedge clk);
        #1;
        pcF = pc; fetch_en = fe; flush = fl;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        int ad;
        int dd;
        logic [31:0] w;
        logic [31:0] pc;

        rst = 1'b0; pcF = 32'hbfc00000; fetch_en = 1'b0; flush = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        @(negedge clk);
        chk("rst_req", {31'h0, inst_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_stall", {31'h0, i_stall}, 32'h1);
        chk("rst_adel", {31'h0, fetch_adel}, 32'h0);
        chk("rst_instr", instrF, 32'h0);
        chk("const_wr_size_wdata", {inst_wr, 29'h0, inst_size} ^ inst_wdata, 32'h2);

        // 1: minimum-latency fetch from kseg1
        @(posedge clk); #1; rst = 1'b1;
        inst_addr_ok = 1'b1; fetch_en = 1'b1;
        @(negedge clk);
        chk("t1_req", {31'h0, inst_req}, 32'h1);
        chk("t1_addr", inst_addr, 32'h1fc00000);
        chk("t1_stall_idle", {31'h0, i_stall}, 32'h1);
        exp_q.push_back(32'h24010001);
        cyc(32'hbfc00000, 1, 0, 0, 1, 32'h24010001);
        chk("t1_state_wait", {29'h0, dbgState}, S_WAIT);
        chk("t1_req_wait", {31'h0, inst_req}, 32'h0);
        cyc(32'hbfc00000, 1, 0, 0, 0, 32'h0);
        chk("t1_valid", {31'h0, instr_valid}, 32'h1);
        chk("t1_stall", {31'h0, i_stall}, 32'h0);
        popChk("t1_instr");

        // 2: returned word held across 4 stall cycles
        cyc(32'hbfc00004, 0, 0, 1, 0, 32'h0);
        chk("t2_addr", inst_addr, 32'h1fc00004);
        exp_q.push_back(32'h8c020010);
        cyc(32'hbfc00004, 0, 0, 0, 1, 32'h8c020010);
        cyc(32'hbfc00004, 0, 0, 0, 0, 32'h0);
        popChk("t2_instr");
        for (int i = 0; i < 3; i++) begin
            cyc(32'hbfc00004, 0, 0, 1, 0, 32'h0);
            chk("t2_hold_instr", instrF, 32'h8c020010);
            chk("t2_hold_req", {31'h0, inst_req}, 32'h0);
            chk("t2_hold_valid", {31'h0, instr_valid}, 32'h1);
        end
        cyc(32'hbfc00004, 1, 0, 0, 0, 32'h0);
        chk("t2_release_valid", {31'h0, instr_valid}, 32'h1);

        // 3: flush while waiting; late response dropped
        cyc(32'hbfc00008, 0, 0, 1, 0, 32'h0);
        cyc(32'hbfc00008, 0, 1, 0, 0, 32'h0);
        chk("t3_flush_wait", {29'h0, dbgState}, S_WAIT);
        cyc(32'hbfc00100, 0, 0, 0, 0, 32'h0);
        chk("t3_discard", {29'h0, dbgState}, S_DISCARD);
        chk("t3_discard_req", {31'h0, inst_req}, 32'h0);
        cyc(32'hbfc00100, 0, 0, 0, 1, 32'hdeadbeef);
        chk("t3_drop_valid", {31'h0, instr_valid}, 32'h0);
        cyc(32'hbfc00100, 0, 0, 1, 0, 32'h0);
        chk("t3_refetch_req", {31'h0, inst_req}, 32'h1);
        chk("t3_refetch_addr", inst_addr, 32'h1fc00100);
        chk("t3_not_deadbeef", {31'h0, instr_valid}, 32'h0);
        exp_q.push_back(32'h3c1d8000);
        cyc(32'hbfc00100, 0, 0, 0, 1, 32'h3c1d8000);
        cyc(32'hbfc00100, 1, 0, 0, 0, 32'h0);
        popChk("t3_instr");

        // 4: addr_ok withheld, flush during REQ, address must not move
        cyc(32'hbfc00104, 0, 0, 0, 0, 32'h0);
        chk("t4_addr_idle", inst_addr, 32'h1fc00104);
        cyc(32'hbfc00104, 0, 0, 0, 0, 32'h0);
        chk("t4_req1", {29'h0, dbgState}, S_REQ);
        chk("t4_addr_req1", inst_addr, 32'h1fc00104);
        cyc(32'hbfc00104, 0, 1, 0, 0, 32'h0);
        chk("t4_addr_req2", inst_addr, 32'h1fc00104);
        cyc(32'hbfc00200, 0, 0, 0, 0, 32'h0);
        chk("t4_addr_req3", inst_addr, 32'h1fc00104);
        chk("t4_req_held", {31'h0, inst_req}, 32'h1);
        cyc(32'hbfc00200, 0, 0, 1, 0, 32'h0);
        chk("t4_addr_accept", inst_addr, 32'h1fc00104);
        cyc(32'hbfc00200, 0, 0, 0, 1, 32'hbadc0de0);
        chk("t4_discard", {29'h0, dbgState}, S_DISCARD);
        cyc(32'hbfc00200, 0, 0, 1, 0, 32'h0);
        chk("t4_refetch_addr", inst_addr, 32'h1fc00200);
        chk("t4_no_valid", {31'h0, instr_valid}, 32'h0);
        exp_q.push_back(32'h27bdffe8);
        cyc(32'hbfc00200, 0, 0, 0, 1, 32'h27bdffe8);
        cyc(32'hbfc00200, 1, 0, 0, 0, 32'h0);
        popChk("t4_instr");

        // flush coinciding with data_ok drops the word and returns to IDLE
        cyc(32'hbfc00210, 0, 0, 1, 0, 32'h0);
        cyc(32'hbfc00210, 0, 1, 0, 1, 32'hcafef00d);
        cyc(32'hbfc00400, 0, 0, 1, 0, 32'h0);
        chk("t7_idle", {29'h0, dbgState}, S_IDLE);
        chk("t7_addr", inst_addr, 32'h1fc00400);
        exp_q.push_back(32'h00000013);
        cyc(32'hbfc00400, 0, 0, 0, 1, 32'h00000013);
        cyc(32'hbfc00400, 1, 0, 0, 0, 32'h0);
        popChk("t7_instr");

        // 5: misaligned PC
        exp_q.push_back(32'h0);
        cyc(32'hbfc00202, 0, 0, 1, 0, 32'h0);
        chk("t5_no_req", {31'h0, inst_req}, 32'h0);
        cyc(32'hbfc00202, 0, 0, 0, 0, 32'h0);
        chk("t5_adel", {31'h0, fetch_adel}, 32'h1);
        chk("t5_stall", {31'h0, i_stall}, 32'h0);
        popChk("t5_instr_nop");
        cyc(32'hbfc00202, 1, 0, 0, 0, 32'h0);
        chk("t5_adel_hold", {31'h0, fetch_adel}, 32'h1);

        // randomised latencies on aligned fetches
        for (int k = 0; k < 4; k++) begin
            pc = 32'hbfc00300 + 32'(k * 4);
            ad = $urandom_range(0, 2);
            dd = $urandom_range(0, 2);
            w  = $urandom;
            for (int j = 0; j < ad; j++) cyc(pc, 0, 0, 0, 0, 32'h0);
            cyc(pc, 0, 0, 1, 0, 32'h0);
            chk("rnd_addr", inst_addr, {3'b000, pc[28:0]});
            chk("rnd_adel_clear", {31'h0, fetch_adel}, 32'h0);
            for (int j = 0; j < dd; j++) begin
                cyc(pc, 0, 0, 0, 0, 32'h0);
                chk("rnd_wait_stall", {31'h0, i_stall}, 32'h1);
            end
            exp_q.push_back(w);
            cyc(pc, 0, 0, 0, 1, w);
            cyc(pc, 1, 0, 0, 0, 32'h0);
            chk("rnd_valid", {31'h0, instr_valid}, 32'h1);
            popChk("rnd_instr");
        end

        // 6: reset during WAIT, then a stale data_ok in IDLE
        cyc(32'hbfc00204, 0, 0, 1, 0, 32'h0);
        cyc(32'hbfc00204, 0, 0, 0, 0, 32'h0);
        chk("t6_wait", {29'h0, dbgState}, S_WAIT);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_state", {29'h0, dbgState}, S_IDLE);
        chk("t6_rst_req", {31'h0, inst_req}, 32'h0);
        chk("t6_rst_stall", {31'h0, i_stall}, 32'h1);
        chk("t6_rst_instr", instrF, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; pcF = 32'h00400000; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hffffffff;
        @(negedge clk);
        chk("t6_idle_req", {31'h0, inst_req}, 32'h1);
        chk("t6_useg_addr", inst_addr, 32'h00400000);
        cyc(32'h00400000, 0, 0, 1, 0, 32'h0);
        chk("t6_stale_ignored", {29'h0, dbgState}, S_REQ);
        exp_q.push_back(32'h11112222);
        cyc(32'h00400000, 0, 0, 0, 1, 32'h11112222);
        cyc(32'h00400000, 1, 0, 0, 0, 32'h0);
        popChk("t6_instr");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
